scan_load_ctrl: RTL and testbench
=================================

# scan_load_ctrl

Sequencer that streams configuration words from a host write port into the coefficient scan chain (twiddles, mux enables, shift coefficients, window coefficients) bit-serially, MSB first.
- Drives the chain's serial input and a clock-enable for the chain's gated scan clock.
- Counts the exact chain length derived from N and W, and reports completion.
- Sits between the host/config bus and the FFT/window coefficient storage.

## Interface
- N, 512, samples per chirp; sets chain geometry
- W, 20, bits per sample
- WORD, 8, host word width; TOTAL must be an exact multiple of WORD (elaboration error otherwise)
- TOTAL (localparam), (N/2)·(W/2) + 2·($clog2(N)−1)·$clog2(N) − ($clog2(N)−1)·$clog2(N) + ($clog2(N)−1)·N + (N/2)·W, i.e. win + shift + mux_en + twiddle bits; 11848 at defaults
- clk_scan  in  1  free-running clock; chain flops are clocked by clk_scan gated with scan_clk_en
- rst  in  1  synchronous active-high reset
- start  in  1  begin a load; honoured only in IDLE
- abort  in  1  abandon load, return to IDLE
- in_data  in  WORD  next chain word; bit WORD−1 is shifted first
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid & in_ready
- scan_data  out  1  to chain scan_in
- scan_clk_en  out  1  enable for the chain clock gate; one chain shift per cycle it is high
- scan_out  in  1  chain tail, used only with SCAN_VERIFY_EN
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, load (and verify) complete
- err  out  1  verify mismatch, sticky until next start or rst; constant 0 without macro
- bit_cnt  out  $clog2(TOTAL+1)  bits shifted in current pass

## Operation
- States: IDLE, LOAD, VERIFY (macro only), DONE.
- IDLE: all outputs 0; start=1 → LOAD, clear bit_cnt, shifter, err. start while busy is ignored.
- LOAD: 1-word shifter + 1-word holding buffer.
  - Each cycle the shifter holds bits: scan_clk_en=1, scan_data=shifter MSB, shift left, bit_cnt+1.
  - Shifter empty: scan_clk_en=0, scan_data=0; the chain holds, with no corruption from host underflow.
  - in_ready=1 when the buffer is empty, or the buffer is full and the shifter is on its last bit (or empty) this cycle, and words accepted < TOTAL/WORD. Buffer moves to the shifter on the cycle the shifter empties, so back-to-back words give continuous scan_clk_en.
  - Word order: first word carries the twiddle MSBs (twiddles, then mux_en, shift_coef, win_coef, as in the chain's MSB-first convention). The controller does not reorder bits.
  - Exit when bit_cnt reaches TOTAL → VERIFY (macro) or DONE.
- VERIFY: see Configuration.
- DONE: done=1 for one cycle, busy=1, then IDLE; bit_cnt holds TOTAL until next start.
- abort (any non-IDLE state): IDLE next cycle, scan_clk_en=0 that cycle. No done pulse. Chain contents undefined. abort beats start/in_valid in the same cycle.
- rst: same as abort plus err=0, bit_cnt=0; applies mid-LOAD.

## Timing
- Reset values: in_ready=0, scan_data=0, scan_clk_en=0, busy=0, done=0, err=0, bit_cnt=0.
- start at edge k → busy=1, in_ready=1 after edge k; first word accepted at edge k+1 → first scan_clk_en=1 in cycle k+2.
- Streaming throughput is WORD cycles per word. A full load with an always-valid host takes TOTAL+3 cycles from start to done (no macro).
- scan_data and scan_clk_en are registered and change together. The chain captures scan_data on the gated edge that ends the enabled cycle.
- in_valid with in_data held is required until accepted. Words after the last are never accepted.

## Configuration
- SCAN_VERIFY_EN defined:
  - During LOAD, a CRC-16-CCITT (poly 0x1021, init 0xFFFF) runs over every bit shifted.
  - VERIFY then runs TOTAL enabled cycles with scan_data=scan_out (recirculate), restoring chain contents, while a second CRC runs over scan_out sampled in each enabled cycle.
  - At the end, err=1 if the two CRCs differ. DONE follows regardless. This adds TOTAL+1 cycles.
- SCAN_VERIFY_EN undefined: no CRC logic, no VERIFY state, scan_out unused, err tied 0.

## Test plan
- N=16, W=4, WORD=4 (TOTAL=108): start, 27 words always valid → exactly 108 scan_clk_en cycles contiguous, done at cycle 111, chain model equals the word stream MSB-first.
- Same, in_valid toggled 1/0 per word → scan_clk_en gaps, bit_cnt stalls, final chain identical, done once.
- Abort after word 10 (bit_cnt=40) → IDLE next cycle, no done; new start reloads and bit_cnt restarts at 0.
- rst asserted mid-LOAD at bit_cnt=57 → all outputs at reset values next cycle; start pulse during busy is ignored (no restart).
- SCAN_VERIFY_EN, chain model correct → 216 enabled cycles total, err=0, chain contents unchanged after verify.
- SCAN_VERIFY_EN, chain model flips one flop between LOAD and VERIFY → err=1, done still pulses; err clears on next start.

Source files
------------

// File: rtl/scan_load_ctrl_if.sv
// scan_load_ctrl_if: host word-write handshake into the scan-chain loader.
// The host (master) offers in_data/in_valid; the loader (slave) answers in_ready.
// A word transfers on a clock edge where in_valid and in_ready are both high.
interface scan_load_ctrl_if #(
    parameter int WORD = 8
);
    logic [WORD-1:0] in_data;
    logic            in_valid;
    logic            in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/scan_load_ctrl.sv
// scan_load_ctrl: streams host words bit-serially (MSB first) into the
// coefficient scan chain and counts exactly TOTAL chain shifts.
// Optional feature macro SCAN_VERIFY_EN: CRC-16-CCITT over the loaded bits,
// then a recirculating read-back pass with a second CRC; err flags a mismatch.
//
//   state  | meaning
//   IDLE   | outputs quiet, waiting for start
//   LOAD   | accepting words and shifting them into the chain
//   VERIFY | recirculating the chain once while checking its CRC (macro only)
//   DONE   | one-cycle completion pulse
module scan_load_ctrl #(
    parameter  int N     = 512,
    parameter  int W     = 20,
    parameter  int WORD  = 8,
    localparam int LG    = $clog2(N),
    localparam int TOTAL = (N/2)*(W/2) + 2*(LG-1)*LG - (LG-1)*LG + (LG-1)*N + (N/2)*W,
    localparam int CW    = $clog2(TOTAL + 1)
) (
    input  logic            clk_scan_i,
    input  logic            rst_i,
    scan_load_ctrl_if.slave host,
    input  logic            start_i,
    input  logic            abort_i,
    output logic            scan_data_o,
    output logic            scan_clk_en_o,
    input  logic            scan_out_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [CW-1:0]   bit_cnt_o
);
    localparam int NWORDS = TOTAL / WORD;
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int SCW    = $clog2(WORD + 1);

    if ((TOTAL % WORD) != 0) begin : g_total_chk
        $error("scan_load_ctrl: chain length %0d is not a multiple of WORD %0d", TOTAL, WORD);
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DONE   = 2'd2
`ifdef SCAN_VERIFY_EN
        , VERIFY = 2'd3
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [WORD-1:0] sh_q, sh_d;
    logic [SCW-1:0]  sh_cnt_q, sh_cnt_d;
    logic [WORD-1:0] hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [WCW-1:0]  words_q, words_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            sd_q, sd_d;
    logic            en_q, en_d;
    logic            in_ready_c;
    logic            accept_c;

`ifdef SCAN_VERIFY_EN
    logic [15:0] crc_l_q, crc_l_d;
    logic [15:0] crc_v_q, crc_v_d;
    logic        err_q, err_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // Next-state, shifter/holding-buffer feed and registered scan outputs.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        sh_cnt_d    = sh_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        words_d     = words_q;
        bit_cnt_d   = bit_cnt_q;
        sd_d        = 1'b0;
        en_d        = 1'b0;
        in_ready_c  = 1'b0;
        accept_c    = 1'b0;
`ifdef SCAN_VERIFY_EN
        crc_l_d     = crc_l_q;
        crc_v_d     = crc_v_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = LOAD;
                    sh_d        = '0;
                    sh_cnt_d    = '0;
                    hold_full_d = 1'b0;
                    words_d     = '0;
                    bit_cnt_d   = '0;
`ifdef SCAN_VERIFY_EN
                    crc_l_d     = 16'hFFFF;
                    crc_v_d     = 16'hFFFF;
                    err_d       = 1'b0;
`endif
                end
            end
            LOAD: begin
                // Room exists if the buffer is free, or it drains into the shifter this cycle.
                in_ready_c = (words_q < WCW'(NWORDS)) && (!hold_full_q || (sh_cnt_q <= SCW'(1)));
                accept_c   = in_ready_c && host.in_valid;
                bit_cnt_d  = bit_cnt_q + CW'(en_q);
`ifdef SCAN_VERIFY_EN
                if (en_q) crc_l_d = crc_step(crc_l_q, sd_q);
`endif
                if (accept_c) words_d = words_q + WCW'(1);
                if (sh_cnt_q != '0) begin
                    en_d     = 1'b1;
                    sd_d     = sh_q[WORD-1];
                    sh_d     = sh_q << 1;
                    sh_cnt_d = sh_cnt_q - SCW'(1);
                    if (sh_cnt_q == SCW'(1)) begin
                        if (hold_full_q) begin
                            sh_d        = hold_q;
                            sh_cnt_d    = SCW'(WORD);
                            hold_full_d = accept_c;
                            if (accept_c) hold_d = host.in_data;
                        end else if (accept_c) begin
                            sh_d     = host.in_data;
                            sh_cnt_d = SCW'(WORD);
                        end
                    end else if (accept_c) begin
                        hold_d      = host.in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (accept_c) begin
                    // Shifter idle: first bit of the new word goes straight out.
                    en_d     = 1'b1;
                    sd_d     = host.in_data[WORD-1];
                    sh_d     = host.in_data << 1;
                    sh_cnt_d = SCW'(WORD - 1);
                end
                if (bit_cnt_q == CW'(TOTAL)) begin
`ifdef SCAN_VERIFY_EN
                    state_d   = VERIFY;
                    bit_cnt_d = '0;
                    en_d      = 1'b1;
`else
                    state_d   = DONE;
`endif
                end
            end
`ifdef SCAN_VERIFY_EN
            VERIFY: begin
                bit_cnt_d = bit_cnt_q + CW'(en_q);
                en_d      = (bit_cnt_d < CW'(TOTAL));
                if (en_q) crc_v_d = crc_step(crc_v_q, scan_out_i);
                if (bit_cnt_q == CW'(TOTAL)) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                    err_d   = (crc_l_q != crc_v_q);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything else and silences the chain clock at once.
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            en_d    = 1'b0;
            sd_d    = 1'b0;
`ifdef SCAN_VERIFY_EN
            err_d   = err_q;
`endif
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_scan_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            sh_cnt_q    <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            words_q     <= '0;
            bit_cnt_q   <= '0;
            sd_q        <= 1'b0;
            en_q        <= 1'b0;
`ifdef SCAN_VERIFY_EN
            crc_l_q     <= 16'hFFFF;
            crc_v_q     <= 16'hFFFF;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            sh_cnt_q    <= sh_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            words_q     <= words_d;
            bit_cnt_q   <= bit_cnt_d;
            sd_q        <= sd_d;
            en_q        <= en_d;
`ifdef SCAN_VERIFY_EN
            crc_l_q     <= crc_l_d;
            crc_v_q     <= crc_v_d;
            err_q       <= err_d;
`endif
        end
    end

    assign host.in_ready = in_ready_c;
    assign scan_clk_en_o = en_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign bit_cnt_o     = bit_cnt_q;

`ifdef SCAN_VERIFY_EN
    // During read-back the chain tail feeds its own head so the contents survive.
    assign scan_data_o = (state_q == VERIFY) ? scan_out_i : sd_q;
    assign err_o       = err_q;
`else
    logic unused_scan_out;
    assign unused_scan_out = scan_out_i;
    assign scan_data_o     = sd_q;
    assign err_o           = 1'b0;
`endif
endmodule

// File: tb/tb_scan_load_ctrl.sv
// tb_scan_load_ctrl: scoreboard bench for scan_load_ctrl at N=16, W=4, WORD=4.
module tb_scan_load_ctrl;
    localparam int N     = 16;
    localparam int W     = 4;
    localparam int WORD  = 4;
    localparam int TOTAL = 108;
    localparam int NW    = TOTAL / WORD;
    localparam int CW    = $clog2(TOTAL + 1);
`ifdef SCAN_VERIFY_EN
    localparam int ENS = 2 * TOTAL;
    localparam int LAT = 2 * TOTAL + 4;
`else
    localparam int ENS = TOTAL;
    localparam int LAT = TOTAL + 3;
`endif

    typedef struct {
        int               start_cyc;
        int               lat;
        int               err;
        bit               chk_chain;
        logic [TOTAL-1:0] chain;
    } done_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          scan_data, scan_clk_en, scan_out, busy, done, err;
    logic [CW-1:0] bit_cnt;

    logic [TOTAL-1:0] chain = '0;
    logic [TOTAL-1:0] exp_chain = '0;
    bit    exp_bits[$];
    done_t exp_done[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    en_count = 0;
    int    done_seen = 0;
    int    flip_req = 0;
    int    flip_done = 0;

    scan_load_ctrl_if #(.WORD(WORD)) host_if ();

    scan_load_ctrl #(.N(N), .W(W), .WORD(WORD)) dut (
        .clk_scan_i    (clk),
        .rst_i         (rst),
        .host          (host_if),
        .start_i       (start),
        .abort_i       (abort),
        .scan_data_o   (scan_data),
        .scan_clk_en_o (scan_clk_en),
        .scan_out_i    (scan_out),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .bit_cnt_o     (bit_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: a plain TOTAL-bit shift register; tail is the oldest bit.
    assign scan_out = chain[TOTAL-1];
    always @(posedge clk) begin
        if (scan_clk_en)
            chain <= {chain[TOTAL-2:0], scan_data};
        else if (flip_req != flip_done && busy && !done && bit_cnt == CW'(TOTAL)) begin
            chain[37] <= ~chain[37];
            flip_done <= flip_req;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected scan bits and completion records as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (scan_clk_en) begin
                en_count++;
                if (exp_bits.size() > 0) begin
                    bit b;
                    b = exp_bits.pop_front();
                    check("scan_bit", int'(scan_data), int'(b));
                end else begin
`ifdef SCAN_VERIFY_EN
                    check("recirc_bit", int'(scan_data), int'(scan_out));
`else
                    checks++;
                    errors++;
                    $display("FAIL extra_scan_bit: got enable with no word queued (cyc %0d)", cyc);
`endif
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with none expected (cyc %0d)", cyc);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("done_bit_cnt", int'(bit_cnt), TOTAL);
                    check("done_enables", en_count, ENS);
                    check("done_err", int'(err), d.err);
                    check("done_bits_left", exp_bits.size(), 0);
                    if (d.lat >= 0) check("done_latency", cyc - d.start_cyc, d.lat);
                    if (d.chk_chain) begin
                        checks++;
                        if (chain !== d.chain) begin
                            errors++;
                            $display("FAIL done_chain: got %h expected %h", chain, d.chain);
                        end
                    end
                end
                done_seen++;
            end
            if (!busy) en_count = 0;
        end
    end

    task automatic do_start(output int sc);
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_bit_cnt", int'(bit_cnt), 0);
        check("start_in_ready", int'(host_if.in_ready), 1);
    endtask

    // mode 0: always valid, 1: valid toggled per word, 2: random gaps.
    task automatic send_words(input int n, input int mode, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            logic [WORD-1:0] w;
            int g;
            if (i == pulse_at) begin
                int bc0, en0;
                bc0 = int'(bit_cnt);
                en0 = int'(scan_clk_en);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_while_busy", int'(bit_cnt), bc0 + en0);
            end
            w = WORD'($urandom);
            host_if.in_data  = w;
            host_if.in_valid = 1'b1;
            g = 0;
            while (!host_if.in_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (!host_if.in_ready) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: word %0d never accepted", i);
                host_if.in_valid = 1'b0;
                return;
            end
            for (int b = WORD - 1; b >= 0; b--) exp_bits.push_back(w[b]);
            exp_chain = {exp_chain[TOTAL-WORD-1:0], w};
            @(negedge clk);
            host_if.in_valid = 1'b0;
            if (mode == 1) @(negedge clk);
            else if (mode == 2) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (done_seen < target && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("done_arrived", done_seen, target);
        g = 0;
        while (busy && g < 4) begin
            @(negedge clk);
            g++;
        end
        check("idle_after_done", int'(busy), 0);
        check("idle_bit_cnt_holds", int'(bit_cnt), TOTAL);
        check("idle_in_ready", int'(host_if.in_ready), 0);
    endtask

    task automatic wait_bit_cnt(input int v);
        int g;
        g = 0;
        while (bit_cnt != CW'(v) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("reach_bit_cnt", int'(bit_cnt), v);
    endtask

    task automatic full_run(input int mode, input int pulse_at, input int err_exp, input bit chk);
        int sc;
        done_t d;
        do_start(sc);
        send_words(NW, mode, pulse_at);
        d.start_cyc = sc;
        d.lat       = (mode == 0) ? LAT : -1;
        d.err       = err_exp;
        d.chk_chain = chk;
        d.chain     = exp_chain;
        exp_done.push_back(d);
        wait_done(done_seen + 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, int'(host_if.in_ready), 0);
        check({tag, "_scan_data"}, int'(scan_data), 0);
        check({tag, "_scan_clk_en"}, int'(scan_clk_en), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_bit_cnt"}, int'(bit_cnt), 0);
    endtask

    initial begin
        int sc;
        host_if.in_data  = '0;
        host_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Always-valid host: contiguous shifting and exact latency.
        full_run(0, -1, 0, 1'b1);
        // Valid toggled per word, plus a start pulse mid-load that must be ignored.
        full_run(1, 5, 0, 1'b1);

        // Abort after ten words, with start and in_valid asserted alongside it.
        do_start(sc);
        send_words(10, 0, -1);
        wait_bit_cnt(40);
        abort = 1'b1;
        start = 1'b1;
        host_if.in_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        host_if.in_valid = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_scan_clk_en", int'(scan_clk_en), 0);
        check("abort_in_ready", int'(host_if.in_ready), 0);
        exp_bits.delete();
        repeat (8) @(negedge clk);
        check("abort_stays_idle", int'(busy), 0);
        full_run(2, -1, 0, 1'b1);

        // Synchronous reset in the middle of a load.
        do_start(sc);
        send_words(15, 0, -1);
        wait_bit_cnt(57);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        exp_bits.delete();
        repeat (4) @(negedge clk);
        check("midrst_stays_idle", int'(busy), 0);

`ifdef SCAN_VERIFY_EN
        // One chain flop disturbed between load and read-back.
        flip_req++;
        full_run(2, -1, 1, 1'b0);
        check("err_sticky_idle", int'(err), 1);
        do_start(sc);
        check("err_cleared_on_start", int'(err), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif
        full_run(2, -1, 0, 1'b1);

        repeat (4) @(negedge clk);
        check("no_pending_done", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
